victory_scorer: RTL

- Downstream stage of the tug-of-war playfield.
- Watches the 9-LED playfield vector and the conditioned player key pulses, and detects a round win.
- Keeps per-player scores, drives two active-low 7-segment digits, and holds the playfield in round reset while a win is shown.
- Latches game over when a player reaches the target score.

---
 rtl/victory_scorer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/victory_scorer.sv
// Tug-of-war round/game scorer: detects edge wins, keeps scores,
// drives score digits and holds the playfield in reset between rounds.
module victory_scorer #(
  parameter int NUM_LEDS    = 9,
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                L,
  input  logic                R,
  input  logic [NUM_LEDS-1:0] led,
  output logic                round_reset,
  output logic                left_win,
  output logic                right_win,
  output logic                game_over,
  output logic [6:0]          hex_left,
  output logic [6:0]          hex_right
);

  localparam logic [1:0] PLAY = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] OVER = 2'd2;

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [3:0]    WS = 4'(WIN_SCORE);

  logic [1:0]    state;
  logic [3:0]    score_l;
  logic [3:0]    score_r;
  logic [HW-1:0] hold_cnt;
  logic          win_l;
  logic          win_r;
  logic          final_round;
  logic          unused_led;

  // Inner LEDs only matter to the playfield itself.
  assign unused_led = ^led;

  assign win_l = led[NUM_LEDS-1] & L & ~R;
  assign win_r = led[0] & R & ~L;

  assign final_round = left_win ? (score_l == WS)
                                : (score_r == WS);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= PLAY;
      score_l     <= 4'd0;
      score_r     <= 4'd0;
      hold_cnt    <= '0;
      round_reset <= 1'b0;
      left_win    <= 1'b0;
      right_win   <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      unique case (state)
        PLAY: begin
          round_reset <= 1'b0;
          unique case (1'b1)
            win_l: begin
              if (score_l < WS) score_l <= score_l + 4'd1;
              left_win    <= 1'b1;
              right_win   <= 1'b0;
              round_reset <= 1'b1;
              hold_cnt    <= HOLD_LOAD;
              state       <= HOLD;
            end
            win_r: begin
              if (score_r < WS) score_r <= score_r + 4'd1;
              left_win    <= 1'b0;
              right_win   <= 1'b1;
              round_reset <= 1'b1;
              hold_cnt    <= HOLD_LOAD;
              state       <= HOLD;
            end
            default: ;
          endcase
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            if (final_round) begin
              state     <= OVER;
              game_over <= 1'b1;
            end else begin
              state       <= PLAY;
              round_reset <= 1'b0;
              left_win    <= 1'b0;
              right_win   <= 1'b0;
            end
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        OVER: ;
        default: state <= PLAY;
      endcase
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'd0:    hex7 = 7'b1000000;
      4'd1:    hex7 = 7'b1111001;
      4'd2:    hex7 = 7'b0100100;
      4'd3:    hex7 = 7'b0110000;
      4'd4:    hex7 = 7'b0011001;
      4'd5:    hex7 = 7'b0010010;
      4'd6:    hex7 = 7'b0000010;
      4'd7:    hex7 = 7'b1111000;
      4'd8:    hex7 = 7'b0000000;
      4'd9:    hex7 = 7'b0010000;
      default: hex7 = 7'b1111111;
    endcase
  endfunction

  assign hex_left  = hex7(score_l);
  assign hex_right = hex7(score_r);

endmodule
